axi_sub_sram_resp: RTL

AXI_SUB_SRAM_RESP -- requirements
Module: axi_sub_sram_resp

---
 rtl/axi_sub_sram_resp.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/axi_sub_sram_resp.sv
// axi_sub_sram_resp -- component responder that maps an address window onto a
// single-port SRAM with a one-cycle read.
//
// After reset the whole SRAM is scrubbed to zero (INIT, requests stalled). Then
// (RUN) one request is accepted per cycle:
//   - Writes complete in the accept cycle. Illegal writes get wr_err in that
//     same cycle.
//   - Reads answer C_LAT cycles after acceptance.
// A request is illegal when:
//   - its address is outside [BASE_ADDR, BASE_ADDR + DEPTH*BC), or
//   - its size is wider than a data word, or
//   - its address is not aligned to its size.
// Illegal requests never reach the SRAM.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   dv, addr, write, user, id,
//   wdata, wstrb, size, last  component request (user, id, last unused)
//   hld                       request stall (high during reset and scrub)
//   rd_err, rdata             read response, C_LAT cycles after acceptance
//   wr_err                    write error, same cycle as the accepted write
//   sram_cs, sram_we,
//   sram_addr, sram_wdata,
//   sram_wbe, sram_rdata      single-port SRAM, read data one cycle after cs
//   init_done                 scrub complete
module axi_sub_sram_resp #(
   parameter int              AW        = 32,
   parameter int              DW        = 32,
   parameter int              UW        = 32,
   parameter int              IW        = 1,
   parameter int              DEPTH     = 256,
   parameter logic [AW-1:0]   BASE_ADDR = '0,
   parameter int              C_LAT     = 1,
   localparam int             BC        = DW / 8,
   localparam int             BW        = $clog2(BC),
   localparam int             XW        = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               dv,
   input  logic [AW-1:0]      addr,
   input  logic               write,
   input  logic [UW-1:0]      user,
   input  logic [IW-1:0]      id,
   input  logic [DW-1:0]      wdata,
   input  logic [BC-1:0]      wstrb,
   input  logic [2:0]         size,
   input  logic               last,
   output logic               hld,
   output logic               rd_err,
   output logic [DW-1:0]      rdata,
   output logic               wr_err,
   output logic               sram_cs,
   output logic               sram_we,
   output logic [XW-1:0]      sram_addr,
   output logic [DW-1:0]      sram_wdata,
   output logic [BC-1:0]      sram_wbe,
   input  logic [DW-1:0]      sram_rdata,
   output logic               init_done
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam logic [AW:0] SPAN = (AW + 1)'(DEPTH * BC);

   state_t           state_q, state_d;
   logic [XW-1:0]    scrub_cnt;
   logic [AW:0]      offset;
   logic             legal;
   logic             rd_accept;
   logic [C_LAT-1:0] rsp_vld;
   logic [C_LAT-1:0] rsp_err;
   logic [DW-1:0]    rsp_data;
   logic             unused_ok;

   assign unused_ok = ^{user, id, last};

   // The offset is one bit wider than addr. An address below the window
   // borrows into the top bit, so one unsigned compare catches both the
   // underflow and the overflow.
   assign offset = {1'b0, addr} - {1'b0, BASE_ADDR};
   assign legal  = (offset < SPAN)
                && (size <= 3'(BW))
                && ((addr & ~({AW{1'b1}} << size)) == '0);

   // NOTE: every signal driven here gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      hld        = 1'b1;
      init_done  = 1'b0;
      sram_cs    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = offset[BW +: XW];
      sram_wdata = wdata;
      sram_wbe   = wstrb;
      wr_err     = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_INIT: begin
               sram_cs    = 1'b1;
               sram_we    = 1'b1;
               sram_addr  = scrub_cnt;
               sram_wdata = '0;
               sram_wbe   = '1;
               if (scrub_cnt == XW'(DEPTH - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
               hld       = 1'b0;
               init_done = 1'b1;
               sram_cs   = dv && legal;
               sram_we   = dv && legal && write;
               wr_err    = dv && write && !legal;
            end
            default: state_d = ST_INIT;
         endcase
      end
   end

   assign rd_accept = dv && !hld && !write;

   // NOTE: sequential state uses non-blocking assignments, so every register
   // samples the values from before the clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_INIT;
         scrub_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_INIT) scrub_cnt <= scrub_cnt + 1'b1;
      end
   end

   // The response tag pipeline is reset, so a reset discards reads in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_vld <= '0;
         rsp_err <= '0;
      end else begin
         rsp_vld[0] <= rd_accept;
         rsp_err[0] <= !legal;
         for (int i = 1; i < C_LAT; i++) begin
            rsp_vld[i] <= rsp_vld[i-1];
            rsp_err[i] <= rsp_err[i-1];
         end
      end
   end

   // Read data is valid one cycle after acceptance. Another C_LAT-1 stages
   // line it up with the tag at the end of the pipeline.
   if (C_LAT == 1) begin : g_no_dreg
      assign rsp_data = sram_rdata;
   end else begin : g_dreg
      logic [DW-1:0] dreg [C_LAT-1];
      // NOTE: the data stages have no reset. They are qualified by rsp_vld,
      // so stale contents never reach rdata.
      always_ff @(posedge clk) begin
         dreg[0] <= sram_rdata;
         for (int i = 1; i < C_LAT - 1; i++) dreg[i] <= dreg[i-1];
      end
      assign rsp_data = dreg[C_LAT-2];
   end

   assign rd_err = !rst && rsp_vld[C_LAT-1] && rsp_err[C_LAT-1];
   assign rdata  = (!rst && rsp_vld[C_LAT-1] && !rsp_err[C_LAT-1]) ? rsp_data : '0;

endmodule
